// File: rtl/req_ack_pkg.sv
// -----------------------------------------------------------------------------
// req_ack_pkg
// Shared definitions for the request/acknowledge scheduler: FSM state
// encoding, default timing parameters and the round-robin pointer helper.
// -----------------------------------------------------------------------------
package req_ack_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_GAP      = 2'd3
    } state_e;

    // Minimum spacing, in cycles, between consecutive req pulses
    localparam int MIN_GAP_DEF     = 8;
    // Last counter value after a req pulse at which ack is still accepted
    localparam int ACK_TIMEOUT_DEF = 15;

    // Next round-robin start index: (idx + 1) mod n
    function automatic int rr_next(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector. Searches the request vector starting
// at the pointer index and wrapping around; the first set bit wins.
//   req_vec_i   : request vector, one bit per client
//   ptr_i       : index holding top priority (must be < N)
//   gnt_idx_o   : index of the selected client (0 when nothing is requested)
//   gnt_valid_o : at least one request bit is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_vec_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [$clog2(N)-1:0] gnt_idx_o,
    output logic                 gnt_valid_o
);

    localparam int IW  = $clog2(N);
    localparam int IW1 = IW + 1;

    // One extra bit so ptr + offset never overflows before the wrap
    logic [IW:0] idx_s;

    // Scan from the highest offset down so the lowest offset that hits is
    // the last assignment and therefore the winner
    always_comb begin
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        idx_s       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx_s = {1'b0, ptr_i} + IW1'(i);
            if (idx_s >= IW1'(N)) begin
                idx_s = idx_s - IW1'(N);
            end else begin
                idx_s = idx_s;
            end
            if (req_vec_i[idx_s[IW-1:0]]) begin
                gnt_idx_o   = idx_s[IW-1:0];
                gnt_valid_o = 1'b1;
            end else begin
                gnt_valid_o = gnt_valid_o;
            end
        end
    end

endmodule

// File: rtl/req_ack_scheduler.sv
// -----------------------------------------------------------------------------
// req_ack_scheduler
// Shares one req/ack resource between N_CLIENTS level-requesting clients.
// A client is granted round-robin, a one-cycle req pulse is issued, and the
// client is told through client_done (ack arrived in time) or client_err
// (ack window expired). Consecutive req pulses are at least MIN_GAP apart.
//   clk, rst_n   : clock, asynchronous active-low reset
//   client_req   : per-client level request
//   client_done  : one-cycle pulse to the owner when ack is accepted
//   client_err   : one-cycle pulse to the owner when ack timed out
//   req / ack    : handshake with the shared resource
//   busy         : FSM outside IDLE
//   owner        : currently or last granted client
//   stray_ack    : sticky, ack observed with no transaction outstanding
// -----------------------------------------------------------------------------
module req_ack_scheduler
    import req_ack_pkg::*;
#(
    parameter int N_CLIENTS   = 4,
    parameter int MIN_GAP     = MIN_GAP_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_CLIENTS-1:0]         client_req,
    output logic [N_CLIENTS-1:0]         client_done,
    output logic [N_CLIENTS-1:0]         client_err,
    output logic                         req,
    input  logic                         ack,
    output logic                         busy,
    output logic [$clog2(N_CLIENTS)-1:0] owner,
    output logic                         stray_ack
);

    localparam int IW      = $clog2(N_CLIENTS);
    // Counter must reach both the timeout decision point and the gap limit
    localparam int CNT_MAX = (ACK_TIMEOUT + 1 > MIN_GAP) ? ACK_TIMEOUT + 1 : MIN_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]     CNT_TMO = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0]     CNT_GAP = CNT_W'(MIN_GAP - 1);
    localparam logic [CNT_W-1:0]     CNT_SAT = {CNT_W{1'b1}};
    localparam logic [N_CLIENTS-1:0] ONE_OH  = {{(N_CLIENTS-1){1'b0}}, 1'b1};

    state_e                 state_q;
    logic                   pend_q;     // owner chosen in IDLE, ISSUE follows
    logic                   req_q;
    logic                   busy_q;
    logic [IW-1:0]          owner_q;
    logic [IW-1:0]          ptr_q;
    logic [N_CLIENTS-1:0]   err_q;
    logic                   stray_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [IW-1:0]          gnt_idx_s;
    logic                   gnt_valid_s;
    logic [N_CLIENTS-1:0]   owner_oh_s;
    logic [N_CLIENTS-1:0]   done_s;

    rr_arbiter #(
        .N (N_CLIENTS)
    ) u_rr_arbiter (
        .req_vec_i   (client_req),
        .ptr_i       (ptr_q),
        .gnt_idx_o   (gnt_idx_s),
        .gnt_valid_o (gnt_valid_s)
    );

    assign owner_oh_s = ONE_OH << owner_q;

    // Done must coincide with the ack cycle, so it is decoded from the
    // registered state and the live ack
    always_comb begin
        if ((state_q == ST_WAIT_ACK) && ack) begin
            done_s = owner_oh_s;
        end else begin
            done_s = '0;
        end
    end

    // Cycle counter: 1 in the cycle after ISSUE, then counts up and saturates
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_ISSUE) begin
            cnt_d = CNT_W'(1);
        end else if ((cnt_q != '0) && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Cycle counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Scheduler FSM with registered req/busy/owner/err/stray outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            err_q   <= '0;
            stray_q <= 1'b0;
        end else begin
            req_q <= 1'b0;
            err_q <= '0;
            if (ack && (state_q != ST_WAIT_ACK)) begin
                stray_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pend_q) begin
                        pend_q  <= 1'b0;
                        state_q <= ST_ISSUE;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (gnt_valid_s) begin
                        owner_q <= gnt_idx_s;
                        ptr_q   <= IW'(rr_next(int'(gnt_idx_s), N_CLIENTS));
                        pend_q  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (ack) begin
                        state_q <= ST_GAP;
                    end else if (cnt_q >= CNT_TMO) begin
                        err_q   <= owner_oh_s;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // A pending request skips IDLE so spacing is exactly MIN_GAP
                    if (cnt_q >= CNT_GAP) begin
                        if (gnt_valid_s) begin
                            owner_q <= gnt_idx_s;
                            ptr_q   <= IW'(rr_next(int'(gnt_idx_s), N_CLIENTS));
                            state_q <= ST_ISSUE;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    pend_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign client_done = done_s;
    assign client_err  = err_q;
    assign req         = req_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign stray_ack   = stray_q;

endmodule

// File: tb/tb_req_ack_scheduler.sv
// -----------------------------------------------------------------------------
// tb_req_ack_scheduler
// Directed bench for req_ack_scheduler with default parameters
// (4 clients, MIN_GAP 8, ACK_TIMEOUT 15). Inputs change 1 ns after the
// rising edge; outputs are sampled 1 ns after that.
// -----------------------------------------------------------------------------
module tb_req_ack_scheduler;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic [3:0] client_req = 4'b0000;
    logic       ack        = 1'b0;
    logic [3:0] client_done;
    logic [3:0] client_err;
    logic       req;
    logic       busy;
    logic [1:0] owner;
    logic       stray_ack;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int r_at = 0;
    int prev_at = 0;

    req_ack_scheduler u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .client_req  (client_req),
        .client_done (client_done),
        .client_err  (client_err),
        .req         (req),
        .ack         (ack),
        .busy        (busy),
        .owner       (owner),
        .stray_ack   (stray_ack)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Free-running cycle index for measuring req spacing
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag, output int at);
        int n;
        n = 0;
        while (req !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_req_seen"}, {31'd0, req}, 32'd1);
        at = cyc;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        #1 rst_n = 1'b0;
        tick();
        check("rst_req",   {31'd0, req},       32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_owner", {30'd0, owner},     32'd0);
        check("rst_done",  {28'd0, client_done}, 32'd0);
        check("rst_err",   {28'd0, client_err},  32'd0);
        check("rst_stray", {31'd0, stray_ack}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // ---------------- single request ----------------
        client_req = 4'b0010;
        tick();
        check("single_req_early", {31'd0, req}, 32'd0);
        tick();
        check("single_req_2cyc", {31'd0, req},   32'd1);
        check("single_owner",    {30'd0, owner}, 32'd1);
        check("single_busy",     {31'd0, busy},  32'd1);
        repeat (4) tick();
        ack = 1'b1;
        #1;
        check("single_done", {28'd0, client_done}, 32'h2);
        check("single_err",  {28'd0, client_err},  32'h0);
        tick();
        ack = 1'b0;
        client_req = 4'b0000;
        #1;
        check("single_done_1pulse", {28'd0, client_done}, 32'h0);
        check("single_no_stray",    {31'd0, stray_ack},   32'd0);
        wait_idle("single");

        // ---------------- all clients, round-robin ----------------
        do_reset();
        client_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_req($sformatf("rr%0d", k), r_at);
            check($sformatf("rr%0d_owner", k), {30'd0, owner}, 32'(k % 4));
            if (k > 0) begin
                check($sformatf("rr%0d_spacing", k), 32'(r_at - prev_at), 32'd8);
            end
            prev_at = r_at;
            repeat (4) tick();
            ack = 1'b1;
            #1;
            check($sformatf("rr%0d_done", k), {28'd0, client_done}, 32'd1 << (k % 4));
            tick();
            ack = 1'b0;
        end
        client_req = 4'b0000;
        wait_idle("rr");

        // ---------------- timeout ----------------
        client_req = 4'b1000;
        wait_req("tmo", r_at);
        check("tmo_owner", {30'd0, owner}, 32'd3);
        client_req = 4'b1100;
        repeat (15) tick();
        check("tmo_err_not_yet", {28'd0, client_err}, 32'h0);
        tick();
        check("tmo_err_16",  {28'd0, client_err},  32'h8);
        check("tmo_no_done", {28'd0, client_done}, 32'h0);
        wait_req("tmo_next", prev_at);
        check("tmo_next_spacing", {31'd0, (prev_at - r_at) >= 16}, 32'd1);
        check("tmo_next_owner",   {30'd0, owner}, 32'd2);
        repeat (4) tick();
        ack = 1'b1;
        #1;
        check("tmo_next_done", {28'd0, client_done}, 32'h4);
        tick();
        ack = 1'b0;
        client_req = 4'b0000;
        wait_idle("tmo");

        // ---------------- ack on the last accepted cycle ----------------
        client_req = 4'b0001;
        wait_req("late", r_at);
        check("late_owner", {30'd0, owner}, 32'd0);
        repeat (15) tick();
        check("late_err_pre", {28'd0, client_err}, 32'h0);
        ack = 1'b1;
        #1;
        check("late_done_15", {28'd0, client_done}, 32'h1);
        tick();
        ack = 1'b0;
        client_req = 4'b0000;
        #1;
        check("late_no_err",   {28'd0, client_err},  32'h0);
        check("late_no_stray", {31'd0, stray_ack},   32'd0);
        wait_idle("late");

        // ---------------- stray ack ----------------
        check("stray_pre", {31'd0, stray_ack}, 32'd0);
        ack = 1'b1;
        #1;
        check("stray_no_done", {28'd0, client_done}, 32'h0);
        tick();
        ack = 1'b0;
        check("stray_set", {31'd0, stray_ack}, 32'd1);
        repeat (3) tick();
        check("stray_sticky", {31'd0, stray_ack},  32'd1);
        check("stray_no_err", {28'd0, client_err}, 32'h0);

        // ---------------- reset mid WAIT_ACK ----------------
        client_req = 4'b0100;
        wait_req("mid", r_at);
        check("mid_owner", {30'd0, owner}, 32'd2);
        client_req = 4'b1001;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_req",   {31'd0, req},         32'd0);
        check("mid_rst_busy",  {31'd0, busy},        32'd0);
        check("mid_rst_owner", {30'd0, owner},       32'd0);
        check("mid_rst_stray", {31'd0, stray_ack},   32'd0);
        check("mid_rst_err",   {28'd0, client_err},  32'h0);
        tick();
        ack = 1'b1;
        #1;
        check("mid_rst_no_done", {28'd0, client_done}, 32'h0);
        tick();
        ack = 1'b0;
        rst_n = 1'b1;
        tick();
        check("mid_first_edge_no_req", {31'd0, req}, 32'd0);
        tick();
        check("mid_regrant_req",   {31'd0, req},   32'd1);
        check("mid_regrant_owner", {30'd0, owner}, 32'd0);
        repeat (4) tick();
        ack = 1'b1;
        #1;
        check("mid_regrant_done", {28'd0, client_done}, 32'h1);
        tick();
        ack = 1'b0;
        client_req = 4'b0000;
        wait_idle("mid");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/req_ack_scheduler.md
REQ_ACK_SCHEDULER -- requirements
Module: req_ack_scheduler

Interface
REQ-001 Parameter N_CLIENTS, default 4, number of requesting clients (2..8).
REQ-002 Parameter MIN_GAP, default 8, minimum cycles from one req pulse to the next.
REQ-003 Parameter ACK_TIMEOUT, default 15, maximum cycles after a req pulse in which ack is accepted.
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port client_req  input  N_CLIENTS  level request per client, held until the client's done or err pulse.
REQ-007 Port client_done  output  N_CLIENTS  one-cycle pulse: the granted client's ack arrived.
REQ-008 Port client_err  output  N_CLIENTS  one-cycle pulse: the granted client's ack timed out.
REQ-009 Port req  output  1  one-cycle request pulse to the shared resource.
REQ-010 Port ack  input  1  acknowledge from the shared resource (nominal latency 4 cycles).
REQ-011 Port busy  output  1  high in every state except IDLE.
REQ-012 Port owner  output  $clog2(N_CLIENTS)  index of the currently or last granted client.
REQ-013 Port stray_ack  output  1  sticky flag: ack seen while no transaction is outstanding.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, WAIT_ACK and GAP.
REQ-015 IDLE: if any client_req bit is high, the block SHALL grant one client round-robin, load owner, and go to ISSUE on the next cycle.
REQ-016 Round-robin priority SHALL start at (last owner + 1) mod N_CLIENTS; after reset, client 0 has top priority.
REQ-017 ISSUE SHALL last exactly one cycle with req=1, then go to WAIT_ACK; req SHALL be 0 in every other state.
REQ-018 The cycle counter SHALL load 1 in the cycle after ISSUE and increment each cycle until the next ISSUE.
REQ-019 WAIT_ACK: ack=1 at counter value 1..ACK_TIMEOUT SHALL pulse client_done[owner] in that cycle and go to GAP.
REQ-020 WAIT_ACK: if the counter reaches ACK_TIMEOUT without ack, the block SHALL pulse client_err[owner] in the next cycle and go to GAP.
REQ-021 GAP SHALL hold until the counter is >= MIN_GAP-1, so that consecutive req pulses are at least MIN_GAP cycles apart; then go to IDLE.
REQ-022 A ready request at GAP exit SHALL be granted directly, going to ISSUE with no extra IDLE cycle, so back-to-back reqs are exactly MIN_GAP cycles apart when requests are pending.
REQ-023 Dropping client_req while the client owns the transaction SHALL NOT abort it; done/err still pulse.
REQ-024 ack in IDLE, ISSUE, GAP or after completion SHALL be ignored for done/err and SHALL set stray_ack, which stays set until reset.
REQ-025 Only the owner's done/err bit SHALL ever pulse, and at most one done or err pulse SHALL occur per req pulse.
REQ-026 The counter SHALL saturate at its maximum and SHALL NOT wrap.

Reset
REQ-027 Asserting rst_n low SHALL immediately force: state IDLE, req=0, busy=0, owner=0, client_done=0, client_err=0, stray_ack=0, counter=0, round-robin pointer at client 0.
REQ-028 Reset in the middle of a transaction SHALL abandon it without a done or err pulse.
REQ-029 The first req after reset deassertion SHALL come no earlier than the second rising clk edge.

Structure
REQ-030 The FSM state enum and the default values of MIN_GAP and ACK_TIMEOUT SHALL live in package req_ack_pkg.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; outputs: grant index, valid).

Verification
REQ-032 Single request: client_req=4'b0010 -> req pulse 2 cycles later, owner=1; ack 4 cycles after req -> client_done=4'b0010 in that cycle.
REQ-033 All clients requesting: client_req=4'b1111 held -> owners in order 0,1,2,3,0, with req pulses exactly 8 cycles apart.
REQ-034 Timeout: no ack after req -> client_err[owner] pulses 16 cycles after req, and the next req comes no earlier than that pulse.
REQ-035 Stray ack: ack=1 while IDLE -> stray_ack=1 and stays 1; no done/err pulses.
REQ-036 Reset mid-WAIT_ACK: rst_n low 2 cycles after req -> all outputs 0 at once, no done pulse; after release, a pending request is regranted starting from client 0.
REQ-037 Formal cover: two complete transactions with distinct owners reachable; assertions: req never high on two cycles less than MIN_GAP apart, and exactly one done or err per req.
